vc_rr_arb_mux4_pipe: RTL and testbench

- 4-input round-robin arbitrated mux stage with a one-entry registered output; sits directly upstream of the memory/network port muxes.
- Picks one valid requester per cycle and drives the select of an internal 4:1 mux.
- Captures the winning message and its 1-bit security domain tag into an output register with val/rdy handshake.
- Each message keeps its domain tag end to end, so downstream logic labels the output by the registered tag.

---
 rtl/vc_rr_arb_mux4_pipe_if.sv | 51 +++++
 rtl/vc_rr_arb_mux4_pipe.sv | 93 +++++++++
 tb/tb_vc_rr_arb_mux4_pipe.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/vc_rr_arb_mux4_pipe_if.sv
// Handshake and data bundle for the 4-input round-robin arbitrated mux stage.
// The slave modport is the arbiter's view; master is the requester/consumer side.
interface vc_rr_arb_mux4_pipe_if #(
  parameter int p_nbits = 32
);
  // requester side
  logic [3:0]         in_val;
  logic [3:0]         in_rdy;
  logic [3:0]         in_domain;
  logic [p_nbits-1:0] in0_msg;
  logic [p_nbits-1:0] in1_msg;
  logic [p_nbits-1:0] in2_msg;
  logic [p_nbits-1:0] in3_msg;

  // consumer side
  logic               out_val;
  logic               out_rdy;
  logic [p_nbits-1:0] out_msg;
  logic               out_domain;
  logic [1:0]         out_src;

  modport slave (
    input  in_val,
    output in_rdy,
    input  in_domain,
    input  in0_msg,
    input  in1_msg,
    input  in2_msg,
    input  in3_msg,
    output out_val,
    input  out_rdy,
    output out_msg,
    output out_domain,
    output out_src
  );

  modport master (
    output in_val,
    input  in_rdy,
    output in_domain,
    output in0_msg,
    output in1_msg,
    output in2_msg,
    output in3_msg,
    input  out_val,
    output out_rdy,
    input  out_msg,
    input  out_domain,
    input  out_src
  );
endinterface

// File: rtl/vc_rr_arb_mux4_pipe.sv
// 4-input round-robin arbitrated mux with a one-entry registered output.
// The winning message travels with its security domain tag; both are captured
// in the same edge so out_domain always labels exactly the message in out_msg.
//
// Output register occupancy:
//   full | meaning
//   0    | empty, any granted requester may load
//   1    | holding a message; reload only if the consumer takes it this cycle
module vc_rr_arb_mux4_pipe #(
  parameter int p_nbits = 32
) (
  input  logic                    clk,
  input  logic                    reset,   // active-low, asynchronous
  vc_rr_arb_mux4_pipe_if.slave    bus
);

  logic               full;
  logic [1:0]         ptr;
  logic [3:0]         grant;
  logic [1:0]         sel;
  logic               can_load;
  logic               fire;
  logic               deq;
  logic [p_nbits-1:0] mux_msg;
  logic               mux_domain;
  logic [p_nbits-1:0] msg_q;
  logic               domain_q;
  logic [1:0]         src_q;

  // Rotating-priority search: start at ptr, wrap 3->0, first valid wins.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    grant = 4'b0000;
    sel   = 2'd0;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && bus.in_val[idx]) begin
        grant[idx] = 1'b1;
        sel        = idx;
        found      = 1'b1;
      end
    end
  end

  // Winner data path: message and its tag are selected by the same sel.
  always_comb begin
    mux_msg = bus.in0_msg;
    case (sel)
      2'd0: mux_msg = bus.in0_msg;
      2'd1: mux_msg = bus.in1_msg;
      2'd2: mux_msg = bus.in2_msg;
      2'd3: mux_msg = bus.in3_msg;
      default: mux_msg = bus.in0_msg;
    endcase
    mux_domain = bus.in_domain[sel];
  end

  // Ready is gated by reset so no requester sees a handshake while held in reset.
  assign can_load   = ~full | bus.out_rdy;
  assign bus.in_rdy = grant & {4{can_load & reset}};
  assign fire       = |(bus.in_val & bus.in_rdy);
  assign deq        = full & bus.out_rdy;

  // Output register and priority pointer; load wins over dequeue on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full     <= 1'b0;
      ptr      <= 2'd0;
      msg_q    <= '0;
      domain_q <= 1'b0;
      src_q    <= 2'd0;
    end else begin
      if (fire) begin
        full     <= 1'b1;
        msg_q    <= mux_msg;
        domain_q <= mux_domain;
        src_q    <= sel;
        ptr      <= sel + 2'd1;
      end else if (deq) begin
        full     <= 1'b0;
      end
    end
  end

  assign bus.out_val    = full;
  assign bus.out_msg    = msg_q;
  assign bus.out_domain = domain_q;
  assign bus.out_src    = src_q;

endmodule

// File: tb/tb_vc_rr_arb_mux4_pipe.sv
// Directed bench for the round-robin arbitrated mux stage.
module tb_vc_rr_arb_mux4_pipe;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  vc_rr_arb_mux4_pipe_if #(.p_nbits(32)) bus ();

  vc_rr_arb_mux4_pipe #(.p_nbits(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] m,
                         input logic d, input logic [1:0] s);
    chk({tag, "_val"}, 64'(bus.out_val), 64'(v));
    chk({tag, "_msg"}, 64'(bus.out_msg), 64'(m));
    chk({tag, "_dom"}, 64'(bus.out_domain), 64'(d));
    chk({tag, "_src"}, 64'(bus.out_src), 64'(s));
  endtask

  initial begin
    logic [31:0] msgs [4];
    logic [3:0]  doms;
    checks = 0;
    errors = 0;

    // reset hold with every requester valid
    reset         = 1'b0;
    bus.in_val    = 4'b1111;
    bus.in_domain = 4'b1010;
    bus.in0_msg   = 32'h0000_0100;
    bus.in1_msg   = 32'h0000_0101;
    bus.in2_msg   = 32'h0000_0102;
    bus.in3_msg   = 32'h0000_0103;
    bus.out_rdy   = 1'b1;
    msgs[0] = 32'h100; msgs[1] = 32'h101; msgs[2] = 32'h102; msgs[3] = 32'h103;
    doms = 4'b1010;
    #1;
    chk("rst_in_rdy", 64'(bus.in_rdy), 64'h0);
    tick();
    tick();
    chk("rst_in_rdy_hold", 64'(bus.in_rdy), 64'h0);
    chk_out("rst", 1'b0, 32'h0, 1'b0, 2'd0);

    // release mid-cycle; first grant goes to requester 0
    reset = 1'b1;
    #1;
    chk("rel_in_rdy", 64'(bus.in_rdy), 64'h1);
    tick();
    chk_out("rel", 1'b1, 32'h100, 1'b0, 2'd0);

    // full-rate rotation with all valid: 1,2,3,0,1,2,3 after the first 0
    for (int i = 1; i < 8; i++) begin
      tick();
      chk_out($sformatf("rot%0d", i), 1'b1, msgs[i % 4], doms[i % 4], 2'(i % 4));
    end

    // backpressure: load in1, then stall with in2 pending
    bus.in_val  = 4'b0010;
    bus.in1_msg = 32'hAAAA_0001;
    tick();
    chk_out("bp_load", 1'b1, 32'hAAAA_0001, 1'b1, 2'd1);
    bus.out_rdy   = 1'b0;
    bus.in_val    = 4'b0100;
    bus.in2_msg   = 32'h2222_0002;
    #1;
    chk("bp_in_rdy0", 64'(bus.in_rdy), 64'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("bp_hold%0d", i), 1'b1, 32'hAAAA_0001, 1'b1, 2'd1);
      chk($sformatf("bp_in_rdy_h%0d", i), 64'(bus.in_rdy), 64'h0);
    end
    bus.out_rdy = 1'b1;
    #1;
    chk("bp_in_rdy_rel", 64'(bus.in_rdy), 64'h4);
    tick();
    chk_out("bp_in2", 1'b1, 32'h2222_0002, 1'b0, 2'd2);

    // wrap-around: ptr=3, only requester 1 valid
    bus.in_val = 4'b0010;
    #1;
    chk("wrap_in_rdy1", 64'(bus.in_rdy), 64'h2);
    tick();
    chk_out("wrap_r1", 1'b1, 32'hAAAA_0001, 1'b1, 2'd1);
    bus.in_val = 4'b1000;
    #1;
    chk("wrap_in_rdy3", 64'(bus.in_rdy), 64'h8);
    tick();
    chk_out("wrap_r3", 1'b1, 32'h0000_0103, 1'b1, 2'd3);
    bus.in_val = 4'b1111;
    #1;
    chk("wrap_ptr0", 64'(bus.in_rdy), 64'h1);

    // domain tracking: in0 tagged L then in3 tagged H
    bus.in_val    = 4'b0001;
    bus.in0_msg   = 32'h0000_1234;
    bus.in3_msg   = 32'h0000_5678;
    bus.in_domain = 4'b1000;
    tick();
    chk_out("dom_l", 1'b1, 32'h1234, 1'b0, 2'd0);
    bus.in_val = 4'b1000;
    tick();
    chk_out("dom_h", 1'b1, 32'h5678, 1'b1, 2'd3);

    // no requests: register drains, ptr holds at 0
    bus.in_val = 4'b0000;
    #1;
    chk("idle_in_rdy", 64'(bus.in_rdy), 64'h0);
    tick();
    chk("idle_out_val", 64'(bus.out_val), 64'h0);
    bus.in_val = 4'b1111;
    #1;
    chk("idle_ptr_hold", 64'(bus.in_rdy), 64'h1);

    // async reset while full
    bus.in_val  = 4'b0100;
    bus.in2_msg = 32'h3333_0003;
    bus.out_rdy = 1'b0;
    tick();
    chk_out("ar_full", 1'b1, 32'h3333_0003, 1'b0, 2'd2);
    #2;
    reset = 1'b0;
    #1;
    chk_out("ar_drop", 1'b0, 32'h0, 1'b0, 2'd0);
    chk("ar_in_rdy", 64'(bus.in_rdy), 64'h0);
    tick();
    reset       = 1'b1;
    bus.in_val  = 4'b0000;
    bus.out_rdy = 1'b1;
    tick();
    chk("ar_no_old", 64'(bus.out_val), 64'h0);
    bus.in_val = 4'b1111;
    #1;
    chk("ar_ptr0", 64'(bus.in_rdy), 64'h1);
    tick();
    chk_out("ar_first", 1'b1, 32'h1234, 1'b0, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
